// File: rtl/shift_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// shift_arbiter_ctrl
//
// This block shares one shifter datapath between NUM_REQ requesters.
// A round-robin arbiter picks one requester and captures its operands.
// The block performs one registered shift and then presents the result on a
// valid/ready handshake. The result is tagged with the id of the requester
// that owns it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (assert async, release sync)
//   req_valid  per-requester request, held with operands until granted
//   req_op     per-requester op, 2 bits each: 00 SRL, 01 SLL, 10 SRA, 11 ROR
//   req_data   per-requester operand, slice i = [WIDTH*i +: WIDTH]
//   req_cnt    per-requester shift amount, slice i = [CNT_W*i +: CNT_W]
//   req_gnt    one-hot accept pulse; operands are captured on this edge
//   rsp_valid  result available
//   rsp_id     index of the requester that owns the result
//   rsp_data   shifted result
//   rsp_ready  consumer accepts the result (ignored outside RESP)
//   busy       FSM is not in IDLE
// ---------------------------------------------------------------------------
module shift_arbiter_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 5,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  input  logic [CNT_W*NUM_REQ-1:0] req_cnt,
  output logic [NUM_REQ-1:0]       req_gnt,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [1:0]        op_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Per-requester views of the flattened input buses.
  logic [1:0]        op_arr   [NUM_REQ];
  logic [WIDTH-1:0]  data_arr [NUM_REQ];
  logic [CNT_W-1:0]  cnt_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]   = req_op[2*gi +: 2];
      assign data_arr[gi] = req_data[WIDTH*gi +: WIDTH];
      assign cnt_arr[gi]  = req_cnt[CNT_W*gi +: CNT_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin pick.
  // The first pass looks at requesters at or above rr_ptr. The second pass
  // wraps around to index 0. The operands of the winner are muxed out in the
  // same loops, so no variable array index is needed.
  // -------------------------------------------------------------------------
  logic              any_valid;
  logic [ID_W-1:0]   win;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_data;
  logic [CNT_W-1:0]  sel_cnt;
  logic [ID_W-1:0]   rr_ptr_next;

  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    sel_op    = '0;
    sel_data  = '0;
    sel_cnt   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_valid && req_valid[j] && (ID_W'(j) >= rr_ptr_reg)) begin
        any_valid = 1'b1;
        win       = ID_W'(j);
        sel_op    = op_arr[j];
        sel_data  = data_arr[j];
        sel_cnt   = cnt_arr[j];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        win       = ID_W'(j);
        sel_op    = op_arr[j];
        sel_data  = data_arr[j];
        sel_cnt   = cnt_arr[j];
      end
    end
  end

  assign rr_ptr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // The grant is combinational. It is valid only in the IDLE cycle in which
  // the capture happens.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign req_gnt[gi] = (state_reg == IDLE) && any_valid && (win == ID_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Shared shifter. One 2W-bit right shift covers every op:
  //   SRL : upper half zero
  //   SRA : upper half filled with the sign bit
  //   ROR : upper half is the operand itself, so the bits wrap around
  //   SLL : operand bit-reversed, then zero-filled right shift, then the
  //         result is reversed back
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]  data_rev;
  logic [WIDTH-1:0]  base;
  logic [WIDTH-1:0]  upper;
  logic [WIDTH-1:0]  res_raw;
  logic [WIDTH-1:0]  res_rev;
  logic [WIDTH-1:0]  shift_result;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign data_rev[gi] = data_reg[WIDTH-1-gi];
      assign res_rev[gi]  = res_raw[WIDTH-1-gi];
    end
  endgenerate

  always_comb begin
    base  = (op_reg == OP_SLL) ? data_rev : data_reg;
    upper = '0;
    case (op_reg)
      OP_SRA:  upper = {WIDTH{data_reg[WIDTH-1]}};
      OP_ROR:  upper = data_reg;
      default: upper = '0;
    endcase
    res_raw      = WIDTH'({upper, base} >> cnt_reg);
    shift_result = (op_reg == OP_SLL) ? res_rev : res_raw;
  end

  // -------------------------------------------------------------------------
  // Control FSM: IDLE -> EXEC -> RESP -> IDLE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      op_reg     <= OP_SRL;
      data_reg   <= '0;
      cnt_reg    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            op_reg     <= sel_op;
            data_reg   <= sel_data;
            cnt_reg    <= sel_cnt;
            id_reg     <= win;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= shift_result;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          // rsp_data keeps its last value after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
module tb_shift_arbiter_ctrl;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  tb_op   [2];
  logic [31:0] tb_data [2];
  logic [4:0]  tb_cnt  [2];
  logic [3:0]  req_op;
  logic [63:0] req_data;
  logic [9:0]  req_cnt;
  logic [1:0]  req_gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  bit   hold_valid = 1'b0;
  logic [1:0] last_gnt;
  exp_t sbq[$];

  always #5 clk = ~clk;

  assign req_op   = {tb_op[1], tb_op[0]};
  assign req_data = {tb_data[1], tb_data[0]};
  assign req_cnt  = {tb_cnt[1], tb_cnt[0]};

  shift_arbiter_ctrl #(
    .NUM_REQ(2), .WIDTH(32), .CNT_W(5), .ID_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_data (req_data),
    .req_cnt  (req_cnt),
    .req_gnt  (req_gnt),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready),
    .busy     (busy)
  );

  // Reference model written with plain SV operators.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [4:0] n);
    logic [31:0] r;
    case (op)
      2'b00: r = a >> n;
      2'b01: r = a << n;
      2'b10: r = $unsigned($signed(a) >>> n);
      default: begin
        if (n == 5'd0) r = a;
        else           r = (a >> n) | (a << (6'd32 - {1'b0, n}));
      end
    endcase
    return r;
  endfunction

  // Advance one cycle. The combinational grant is sampled just before the
  // edge, and the expected result is pushed to the scoreboard. Granted
  // requesters drop valid afterwards unless hold_valid is set.
  task automatic step();
    exp_t e;
    #1;
    last_gnt = req_gnt;
    for (int i = 0; i < 2; i++) begin
      if (req_gnt[i]) begin
        e.id   = 2'(i);
        e.data = model(tb_op[i], tb_data[i], tb_cnt[i]);
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
    if (!hold_valid) req_valid = req_valid & ~last_gnt;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (rsp_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   got;
    bit   seen;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    assertions++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 ||
        rsp_data !== 32'd0 || req_gnt !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b id=%0d data=%h gnt=%b required 0 0 0 0 00",
               rsp_valid, busy, rsp_id, rsp_data, req_gnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Start an op on req0 (rr_ptr moves to 1), then reset it in EXEC.
    tb_op[0] = 2'b00; tb_data[0] = 32'hDEAD_BEEF; tb_cnt[0] = 5'd8;
    tb_op[1] = 2'b11; tb_data[1] = 32'h0F0F_1234; tb_cnt[1] = 5'd12;
    req_valid = 2'b01;
    step();
    assertions++;
    if (last_gnt !== 2'b01) begin
      failures++;
      $display("FAIL t1_first_gnt: got %b required 01", last_gnt);
    end
    rst_n = 1'b0;
    sbq.delete();
    #1;
    assertions++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t1_mid_exec_reset: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    assertions++;
    if (seen) begin
      failures++;
      $display("FAIL t1_dropped_op: got a response, required none");
    end
    // rr_ptr went back to 0, so with both valid requester 0 wins.
    req_valid = 2'b11;
    step();
    assertions++;
    if (last_gnt !== 2'b01) begin
      failures++;
      $display("FAIL t1_rr_after_reset: got %b required 01", last_gnt);
    end
    for (int r = 0; r < 2; r++) begin
      wait_rsp(got);
      assertions++;
      if (!got || sbq.size() == 0) begin
        failures++;
        $display("FAIL t1_rsp%0d: got no response, required one", r);
      end else begin
        e = sbq.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          failures++;
          $display("FAIL t1_rsp%0d: got id=%0d data=%h required id=%0d data=%h",
                   r, rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    step();
  endtask

  task automatic test_single_srl();
    exp_t e;
    tb_op[0] = 2'b00; tb_data[0] = 32'h8000_00F0; tb_cnt[0] = 5'd4;
    req_valid = 2'b01;
    step();
    assertions++;
    if (last_gnt !== 2'b01) begin
      failures++;
      $display("FAIL t2_gnt: got %b required 01", last_gnt);
    end
    step();
    assertions++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0800_000F) begin
      failures++;
      $display("FAIL t2_srl: got valid=%b id=%0d data=%h required 1 0 0800000f",
               rsp_valid, rsp_id, rsp_data);
    end
    assertions++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL t2_scoreboard: got empty queue, required one entry");
    end else begin
      e = sbq.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data) begin
        failures++;
        $display("FAIL t2_scoreboard: got id=%0d data=%h required id=%0d data=%h",
                 rsp_id, rsp_data, e.id, e.data);
      end
    end
    step();
  endtask

  task automatic test_ops_cnt31();
    logic [1:0]  ops  [3];
    logic [31:0] want [3];
    exp_t e;
    bit   got;
    ops[0] = 2'b10; want[0] = 32'hFFFF_FFFF;
    ops[1] = 2'b01; want[1] = 32'h8000_0000;
    ops[2] = 2'b11; want[2] = 32'h0000_0003;
    for (int t = 0; t < 3; t++) begin
      tb_op[1] = ops[t]; tb_data[1] = 32'h8000_0001; tb_cnt[1] = 5'd31;
      req_valid = 2'b10;
      wait_rsp(got);
      assertions++;
      if (!got || sbq.size() == 0) begin
        failures++;
        $display("FAIL t3_op%0d: got no response, required %h", ops[t], want[t]);
      end else begin
        e = sbq.pop_front();
        if (rsp_id !== 2'd1 || rsp_data !== want[t] || rsp_data !== e.data) begin
          failures++;
          $display("FAIL t3_op%0d: got id=%0d data=%h required id=1 data=%h",
                   ops[t], rsp_id, rsp_data, want[t]);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_gnt = 0;
    int   prev  = 0;
    logic [1:0] exp_id = 2'd0;
    bit   got;
    tb_op[0] = 2'b00; tb_data[0] = 32'hA5A5_0F0F; tb_cnt[0] = 5'd3;
    tb_op[1] = 2'b11; tb_data[1] = 32'h1357_9BDF; tb_cnt[1] = 5'd17;
    hold_valid = 1'b1;
    req_valid  = 2'b11;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 16 && n_gnt < 4; k++) begin
      step();
      if (|last_gnt) begin
        assertions++;
        if (last_gnt !== (2'b01 << exp_id)) begin
          failures++;
          $display("FAIL t4_gnt_order: got %b required %b", last_gnt, 2'b01 << exp_id);
        end
        if (n_gnt > 0) begin
          assertions++;
          if (cyc - prev != 3) begin
            failures++;
            $display("FAIL t4_gnt_spacing: got %0d cycles required 3", cyc - prev);
          end
        end
        prev   = cyc;
        exp_id = exp_id ^ 2'd1;
        n_gnt++;
      end
      if (rsp_valid) begin
        assertions++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL t4_rsp: got unexpected id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sbq.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL t4_rsp: got id=%0d data=%h required id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
    hold_valid = 1'b0;
    req_valid  = 2'b00;
    assertions++;
    if (n_gnt != 4) begin
      failures++;
      $display("FAIL t4_gnt_count: got %0d grants required 4", n_gnt);
    end
    wait_rsp(got);
    assertions++;
    if (!got || sbq.size() == 0) begin
      failures++;
      $display("FAIL t4_last_rsp: got no response, required one");
    end else begin
      e = sbq.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data) begin
        failures++;
        $display("FAIL t4_last_rsp: got id=%0d data=%h required id=%0d data=%h",
                 rsp_id, rsp_data, e.id, e.data);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [31:0] held;
    bit   got;
    tb_op[0] = 2'b10; tb_data[0] = 32'h9000_0000; tb_cnt[0] = 5'd5;
    tb_op[1] = 2'b01; tb_data[1] = 32'h0000_00FF; tb_cnt[1] = 5'd9;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    step();
    assertions++;
    if (last_gnt !== 2'b01) begin
      failures++;
      $display("FAIL t5_gnt: got %b required 01", last_gnt);
    end
    step();
    held = rsp_data;
    for (int k = 0; k < 10; k++) begin
      step();
      assertions++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || busy !== 1'b1 || last_gnt !== 2'b00) begin
        failures++;
        $display("FAIL t5_stall%0d: got valid=%b data=%h busy=%b gnt=%b required 1 %h 1 00",
                 k, rsp_valid, rsp_data, busy, last_gnt, held);
      end
    end
    rsp_ready = 1'b1;
    assertions++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL t5_rsp: got empty queue, required one entry");
    end else begin
      e = sbq.pop_front();
      if (rsp_id !== e.id || rsp_data !== e.data) begin
        failures++;
        $display("FAIL t5_rsp: got id=%0d data=%h required id=%0d data=%h",
                 rsp_id, rsp_data, e.id, e.data);
      end
    end
    step();
    assertions++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== held) begin
      failures++;
      $display("FAIL t5_release: got valid=%b busy=%b data=%h required 0 0 %h",
               rsp_valid, busy, rsp_data, held);
    end
    wait_rsp(got);
    assertions++;
    if (!got || sbq.size() == 0) begin
      failures++;
      $display("FAIL t5_req1_rsp: got no response, required one");
    end else begin
      e = sbq.pop_front();
      if (rsp_id !== 2'd1 || rsp_id !== e.id || rsp_data !== e.data) begin
        failures++;
        $display("FAIL t5_req1_rsp: got id=%0d data=%h required id=1 data=%h",
                 rsp_id, rsp_data, e.data);
      end
    end
    step();
  endtask

  task automatic test_cnt_zero();
    exp_t e;
    bit   got;
    for (int op = 0; op < 4; op++) begin
      tb_op[0] = 2'(op); tb_data[0] = 32'h1234_5678; tb_cnt[0] = 5'd0;
      req_valid = 2'b01;
      wait_rsp(got);
      assertions++;
      if (!got || sbq.size() == 0) begin
        failures++;
        $display("FAIL t6_op%0d: got no response, required 12345678", op);
      end else begin
        e = sbq.pop_front();
        if (rsp_data !== 32'h1234_5678 || rsp_data !== e.data || rsp_id !== e.id) begin
          failures++;
          $display("FAIL t6_op%0d: got id=%0d data=%h required id=0 data=12345678",
                   op, rsp_id, rsp_data);
        end
      end
      step();
    end
  endtask

  initial begin
    tb_op[0] = 2'b00; tb_data[0] = '0; tb_cnt[0] = '0;
    tb_op[1] = 2'b00; tb_data[1] = '0; tb_cnt[1] = '0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_srl();
    test_ops_cnt31();
    test_back_to_back();
    test_backpressure();
    test_cnt_zero();
    assertions++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
